uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of payload bits per frame (legal 5..8).
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tx_valid  input  1  tx_data holds a byte to send.
REQ-007 tx_data  input  8  payload; bit 0 sent first; bits above DATA_BITS-1 ignored.
REQ-008 tx_ready  output  1  block can accept a byte this cycle.
REQ-009 baud_tick  input  1  single-cycle bit-period strobe from the baud generator.
REQ-010 baud_en  output  1  enable to the baud generator; its counter restarts when low.
REQ-011 txd  output  1  serial line, idle high.
REQ-012 tx_done  output  1  one-cycle pulse when the final stop bit period ends.

Function
REQ-013 The block SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-014 tx_ready SHALL be 1 exactly when the state is IDLE; it is decoded from the state register only, with no combinational path from tx_valid.
REQ-015 Acceptance SHALL occur on a cycle with tx_valid=1 and tx_ready=1: latch tx_data, set txd=0 and baud_en=1 on the next edge, enter START.
REQ-016 In IDLE, baud_tick SHALL be ignored; txd=1 and baud_en=0.
REQ-017 START on baud_tick: txd = data bit 0, bit index = 0, enter DATA.
REQ-018 DATA on baud_tick, index < DATA_BITS-1: increment the index and drive the next data bit.
REQ-019 DATA on baud_tick, index = DATA_BITS-1: enter PAR with txd = parity bit if PARITY≠0; otherwise enter STOP with txd=1.
REQ-020 Parity bit SHALL be the XOR of the DATA_BITS payload bits (even), or its inverse (odd).
REQ-021 PAR on baud_tick: txd=1, enter STOP, stop count = 0.
REQ-022 STOP on baud_tick, stop count < STOP_BITS-1: increment the count and hold txd=1.
REQ-023 STOP on baud_tick, last stop bit: enter IDLE, set baud_en=0, pulse tx_done for 1 cycle.
REQ-024 Each bit SHALL be held on txd from the edge after one baud_tick (or acceptance, for the start bit) until the edge after the next baud_tick.
REQ-025 Frame length SHALL be 1+DATA_BITS+(PARITY≠0)+STOP_BITS bit periods.
REQ-026 tx_ready SHALL rise on the same edge as tx_done, so a new byte can be accepted the following cycle.
REQ-027 baud_en SHALL be low for at least one cycle between frames, so every frame starts with a freshly cleared baud counter.
REQ-028 tx_valid and tx_data changes while not IDLE SHALL have no effect on the frame in flight.
REQ-029 baud_tick coincident with acceptance SHALL be ignored; the start bit lasts until the next baud_tick.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, txd=1, baud_en=0, tx_done=0, tx_ready=1 on the following cycle, and data, index and stop count cleared.
REQ-031 rst mid-frame SHALL abort the frame immediately: txd returns to 1 on the next edge, and no tx_done is pulsed.

Verification
REQ-032 Bench SHALL pair the block with the team baud generator, DIV=4, defaults 8N1; send 0x55 -> txd reads 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; then one tx_done pulse; tx_ready low for the whole frame.
REQ-033 Send 0xA3 then 0x0F back-to-back with tx_valid held -> two contiguous correct frames; baud_en low exactly 1 cycle between them; 2 tx_done pulses.
REQ-034 PARITY=1, send 0x07 -> parity bit 1; PARITY=2, send 0x07 -> parity bit 0; STOP_BITS=2 -> stop high for 8 cycles.
REQ-035 DATA_BITS=5, send 0xFF -> start bit + 5 ones + stop bit, 7 bit periods total; tx_data[7:5] ignored.
REQ-036 Assert rst during data bit 3 -> txd=1, tx_ready=1 and baud_en=0 after one edge, no tx_done; a following byte 0x3C is transmitted correctly.
REQ-037 Stray baud_tick pulses forced in IDLE -> txd stays 1 and the state stays IDLE.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with parity/stop-bit options, driven by an external baud strobe
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       baud_tick,
    output logic       baud_en,
    output logic       txd,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Payload bits above DATA_BITS-1 are dropped at acceptance so parity only sees real payload
    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t     state, state_next;
    logic [7:0] data_q, data_next;
    logic [2:0] idx_q, idx_next;
    logic       stop_q, stop_next;
    logic       txd_q, txd_next;
    logic       done_q, done_next;
    logic       parity_bit;

    assign parity_bit = (^data_q) ^ (PARITY == 2);

    // State register plus the registered datapath; txd is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= 8'd0;
            idx_q  <= 3'd0;
            stop_q <= 1'b0;
            txd_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            idx_q  <= idx_next;
            stop_q <= stop_next;
            txd_q  <= txd_next;
            done_q <= done_next;
        end
    end

    // Next-state logic: every bit advances only on baud_tick, IDLE ignores the tick entirely
    always_comb begin
        state_next = state;
        data_next  = data_q;
        idx_next   = idx_q;
        stop_next  = stop_q;
        txd_next   = txd_q;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                txd_next = 1'b1;
                if (tx_valid) begin
                    data_next  = tx_data & DATA_MASK;
                    idx_next   = 3'd0;
                    stop_next  = 1'b0;
                    txd_next   = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    txd_next   = data_q[0];
                    idx_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (idx_q != LAST_IDX) begin
                        idx_next = idx_q + 3'd1;
                        txd_next = data_q[idx_q + 3'd1];
                    end else if (PARITY != 0) begin
                        txd_next   = parity_bit;
                        state_next = PAR;
                    end else begin
                        txd_next   = 1'b1;
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end
                end
            end
            PAR: begin
                if (baud_tick) begin
                    txd_next   = 1'b1;
                    stop_next  = 1'b0;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    txd_next = 1'b1;
                    if (stop_q != STOP_LAST) begin
                        stop_next = stop_q + 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from registers only; baud_en drops in IDLE so each frame restarts the divider
    always_comb begin
        tx_ready = (state == IDLE);
        baud_en  = (state != IDLE);
        txd      = txd_q;
        tx_done  = done_q;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx across four frame formats
module tb_uart_tx;

    localparam int NCFG = 4;
    localparam int DIV  = 4;

    // Config 0: 8N1, 1: 8E1, 2: 8O2, 3: 5N1
    function automatic int db_of(input int g);
        return (g == 3) ? 5 : 8;
    endfunction
    function automatic int par_of(input int g);
        return (g == 1) ? 1 : (g == 2) ? 2 : 0;
    endfunction
    function automatic int sb_of(input int g);
        return (g == 2) ? 2 : 1;
    endfunction

    logic            clk = 1'b0;
    logic [NCFG-1:0] rst;
    logic [NCFG-1:0] tx_valid;
    logic [7:0]      tx_data [NCFG];
    logic [NCFG-1:0] tx_ready;
    logic [NCFG-1:0] baud_tick;
    logic [NCFG-1:0] baud_en;
    logic [NCFG-1:0] txd;
    logic [NCFG-1:0] tx_done;
    logic [NCFG-1:0] force_tick;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        logic [1:0] cnt;

        // Baud generator model: counter held clear while baud_en is low, strobe every DIV cycles
        always @(posedge clk) begin
            if (rst[g] || !baud_en[g]) cnt <= 2'd0;
            else if (cnt == 2'(DIV - 1)) cnt <= 2'd0;
            else cnt <= cnt + 2'd1;
        end
        assign baud_tick[g] = (baud_en[g] && cnt == 2'(DIV - 1)) | force_tick[g];

        uart_tx #(
            .DATA_BITS(db_of(g)),
            .PARITY(par_of(g)),
            .STOP_BITS(sb_of(g))
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .tx_valid(tx_valid[g]),
            .tx_data(tx_data[g]),
            .tx_ready(tx_ready[g]),
            .baud_tick(baud_tick[g]),
            .baud_en(baud_en[g]),
            .txd(txd[g]),
            .tx_done(tx_done[g])
        );
    end

    function automatic int frame_len(input int g);
        return 1 + db_of(g) + ((par_of(g) != 0) ? 1 : 0) + sb_of(g);
    endfunction

    // Line level of bit period i of a frame carrying d: start, payload LSB first, parity, stops
    function automatic logic exp_bit(input int g, input logic [7:0] d, input int i);
        int db;
        logic [7:0] m;
        db = db_of(g);
        m  = d & (8'hFF >> (8 - db));
        if (i == 0) return 1'b0;
        if (i <= db) return m[i - 1];
        if (par_of(g) != 0 && i == db + 1) return (^m) ^ (par_of(g) == 2);
        return 1'b1;
    endfunction

    function automatic logic [3:0] obs(input int g);
        return {txd[g], tx_ready[g], tx_done[g], baud_en[g]};
    endfunction

    // Sends one byte and checks every cycle of the frame; entered and left at a negedge
    task automatic send(input int g, input logic [7:0] d, input bit hold, input bit tick_at_accept,
                        input string name);
        int w;
        int n;
        logic [3:0] e;
        w = 0;
        while (tx_ready[g] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (tx_ready[g] !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_wait: tx_ready=%b expected 1", name, tx_ready[g]);
        end
        tx_data[g]    = d;
        tx_valid[g]   = 1'b1;
        force_tick[g] = tick_at_accept;
        @(posedge clk);
        n = frame_len(g);
        for (int k = 0; k < DIV * n; k++) begin
            @(negedge clk);
            force_tick[g] = 1'b0;
            e = {exp_bit(g, d, k / DIV), 1'b0, 1'b0, 1'b1};
            tests++;
            if (obs(g) !== e) begin
                fails++;
                $display("FAIL %s cycle %0d: {txd,ready,done,en}=%b expected %b", name, k, obs(g), e);
            end
            tx_valid[g] = hold ? 1'b1 : ((k < DIV * n - 1) ? 1'($urandom) : 1'b0);
            tx_data[g]  = 8'($urandom);
        end
        @(negedge clk);
        tests++;
        if (obs(g) !== 4'b1110) begin
            fails++;
            $display("FAIL %s frame_end: {txd,ready,done,en}=%b expected 1110", name, obs(g));
        end
        if (!hold) begin
            tx_valid[g] = 1'b0;
            @(negedge clk);
            tests++;
            if (obs(g) !== 4'b1100) begin
                fails++;
                $display("FAIL %s after_done: {txd,ready,done,en}=%b expected 1100", name, obs(g));
            end
        end
    endtask

    task automatic test_reset();
        rst        = '1;
        tx_valid   = '0;
        force_tick = '0;
        for (int g = 0; g < NCFG; g++) tx_data[g] = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            tests++;
            if (obs(g) !== 4'b1100) begin
                fails++;
                $display("FAIL reset cfg%0d: {txd,ready,done,en}=%b expected 1100", g, obs(g));
            end
        end
        rst = '0;
        @(negedge clk);
    endtask

    task automatic test_idle_ticks();
        for (int c = 0; c < 12; c++) begin
            force_tick = 4'($urandom) | 4'b0001;
            @(negedge clk);
            for (int g = 0; g < NCFG; g++) begin
                tests++;
                if (obs(g) !== 4'b1100) begin
                    fails++;
                    $display("FAIL idle_tick cfg%0d c%0d: {txd,ready,done,en}=%b expected 1100", g, c, obs(g));
                end
            end
        end
        force_tick = '0;
    endtask

    task automatic test_back_to_back();
        send(0, 8'hA3, 1'b1, 1'b0, "b2b_a3");
        send(0, 8'h0F, 1'b0, 1'b0, "b2b_0f");
    endtask

    task automatic test_parity_stop();
        send(1, 8'h07, 1'b0, 1'b0, "even_07");
        send(2, 8'h07, 1'b0, 1'b0, "odd2_07");
    endtask

    task automatic test_five_bits();
        send(3, 8'hFF, 1'b0, 1'b0, "db5_ff");
        send(3, 8'hE0, 1'b0, 1'b0, "db5_e0");
    endtask

    task automatic test_reset_abort();
        tx_data[0]  = 8'h55;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4 * DIV + 2; k++) begin
            @(negedge clk);
            tx_valid[0] = 1'b0;
        end
        tests++;
        if (obs(0) !== 4'b0001) begin
            fails++;
            $display("FAIL abort_pre: {txd,ready,done,en}=%b expected 0001", obs(0));
        end
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        tests++;
        if (obs(0) !== 4'b1100) begin
            fails++;
            $display("FAIL abort_rst: {txd,ready,done,en}=%b expected 1100", obs(0));
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            tests++;
            if (obs(0) !== 4'b1100) begin
                fails++;
                $display("FAIL abort_idle c%0d: {txd,ready,done,en}=%b expected 1100", c, obs(0));
            end
        end
        send(0, 8'h3C, 1'b0, 1'b0, "post_rst_3c");
    endtask

    task automatic test_random();
        for (int g = 0; g < NCFG; g++) begin
            for (int i = 0; i < 6; i++) begin
                send(g, 8'($urandom), (i < 5) ? 1'($urandom) : 1'b0, 1'($urandom), "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_ticks();
        send(0, 8'h55, 1'b0, 1'b0, "8n1_55");
        test_back_to_back();
        test_parity_stop();
        test_five_bits();
        send(0, 8'h81, 1'b0, 1'b1, "accept_tick");
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
